// File: rtl/div_unit.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned,
// with divide-by-zero detection and back-to-back start acceptance from DONE.
module div_unit #(
  parameter int unsigned width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [width-1:0] dividend,
  input  logic [width-1:0] divisor,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned cw = $clog2(width + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [width-1:0] dvd, dvd_n;
  logic [width-1:0] dvs, dvs_n;
  logic [width-1:0] prem, prem_n;
  logic [width-1:0] quot_n, rem_n;
  logic [cw-1:0]    cnt, cnt_n;
  logic             neg_q, neg_q_n, neg_r, neg_r_n, dbz_n;
  logic             accept, a_neg, b_neg, qbit;
  logic [width:0]   shifted, diff;
  logic [width-1:0] q_mag, r_mag;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state, iteration step and result selection
  always_comb begin
    state_n = state;
    dvd_n   = dvd;
    dvs_n   = dvs;
    prem_n  = prem;
    cnt_n   = cnt;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    quot_n  = quotient;
    rem_n   = remainder;
    dbz_n   = div_by_zero;

    accept  = start && (state != BUSY);
    a_neg   = is_signed & dividend[width-1];
    b_neg   = is_signed & divisor[width-1];

    // Remainder gains the next dividend bit; subtraction keeps it when non-negative
    shifted = {prem, dvd[width-1]};
    diff    = shifted - {1'b0, dvs};
    qbit    = ~diff[width];
    q_mag   = {dvd[width-2:0], qbit};
    r_mag   = qbit ? diff[width-1:0] : shifted[width-1:0];

    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept) begin
          dvd_n   = a_neg ? -dividend : dividend;
          dvs_n   = b_neg ? -divisor : divisor;
          prem_n  = '0;
          neg_q_n = a_neg ^ b_neg;
          neg_r_n = a_neg;
          dbz_n   = 1'b0;
          if (divisor == '0) begin
            state_n = DONE;
            quot_n  = '1;
            rem_n   = dividend;
            dbz_n   = 1'b1;
          end else begin
            state_n = BUSY;
            cnt_n   = cw'(width);
          end
        end
      end
      BUSY: begin
        dvd_n  = q_mag;
        prem_n = r_mag;
        cnt_n  = cnt - cw'(1);
        if (cnt == cw'(1)) begin
          state_n = DONE;
          quot_n  = neg_q ? -q_mag : q_mag;
          rem_n   = neg_r ? -r_mag : r_mag;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      dvd         <= dvd_n;
      dvs         <= dvs_n;
      prem        <= prem_n;
      cnt         <= cnt_n;
      neg_q       <= neg_q_n;
      neg_r       <= neg_r_n;
      quotient    <= quot_n;
      remainder   <= rem_n;
      div_by_zero <= dbz_n;
      busy        <= (state_n == BUSY);
      done        <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands
// compared against an integer-arithmetic reference model.
module tb_div_unit;

  localparam int unsigned W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  div_unit #(.width(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .is_signed(is_signed),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  // Reference: plain integer division, truncating toward zero when signed
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      sa = s ? int'($signed(a)) : int'(a);
      sb = s ? int'($signed(b)) : int'(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end
  endtask

  // Issue one division from a mid-cycle point; scramble inputs after acceptance
  task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                         output int lat, output int busy_cnt);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clock); #1;
    start = 1'b0;
    is_signed = 1'($urandom);
    dividend = W'($urandom);
    divisor = W'($urandom);
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clock); #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, expected all zero",
               quotient, remainder, busy, done, div_by_zero);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_directed;
    logic [W-1:0] va [4] = '{16'd100, 16'hFFF9, 16'hFFF9, 16'h8000};
    logic [W-1:0] vb [4] = '{16'd7, 16'h0002, 16'h0002, 16'hFFFF};
    logic         vs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] eq [4] = '{16'd14, 16'hFFFD, 16'h7FFC, 16'h8000};
    logic [W-1:0] er [4] = '{16'd2, 16'hFFFF, 16'h0001, 16'h0000};
    logic [W-1:0] q, r;
    logic z;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_div(vs[i], va[i], vb[i], q, r, z, lat, bc);
      checks++;
      if (q !== eq[i] || r !== er[i] || z !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d_result: got q=%h r=%h dbz=%b, expected q=%h r=%h dbz=0",
                 i, q, r, z, eq[i], er[i]);
      end
      checks++;
      if (lat !== 17 || bc !== 16) begin
        errors++;
        $display("FAIL directed_%0d_timing: got latency=%0d busy_cycles=%0d, expected 17/16",
                 i, lat, bc);
      end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || quotient !== eq[i] || remainder !== er[i]) begin
        errors++;
        $display("FAIL directed_%0d_hold: got done=%b q=%h r=%h, expected done=0 q=%h r=%h",
                 i, done, quotient, remainder, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_by_zero;
    logic [W-1:0] q, r;
    logic z;
    int lat, bc;
    for (int s = 0; s < 2; s++) begin
      run_div(1'(s), 16'h1234, 16'h0000, q, r, z, lat, bc);
      checks++;
      if (q !== 16'hFFFF || r !== 16'h1234 || z !== 1'b1 || lat !== 1) begin
        errors++;
        $display("FAIL div_zero_s%0d: got q=%h r=%h dbz=%b latency=%0d, expected FFFF 1234 1 1",
                 s, q, r, z, lat);
      end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || div_by_zero !== 1'b1) begin
        errors++;
        $display("FAIL div_zero_hold_s%0d: got done=%b dbz=%b, expected done=0 dbz=1",
                 s, done, div_by_zero);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, n;
    start = 1'b1; is_signed = 1'b0; dividend = 16'd100; divisor = 16'd7;
    @(posedge clock); #1;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 4) begin
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
      end else begin
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
      end
      @(posedge clock); #1;
      lat++;
    end
    checks++;
    if (quotient !== 16'd14 || remainder !== 16'd2 || lat !== 17) begin
      errors++;
      $display("FAIL ignore_busy_start: got q=%0d r=%0d latency=%0d, expected 14 2 17",
               quotient, remainder, lat);
    end
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    n = 0;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (quotient !== 16'd10 || remainder !== 16'd0 || n !== 16) begin
      errors++;
      $display("FAIL b2b_result: got q=%0d r=%0d edges=%0d, expected 10 0 16",
               quotient, remainder, n);
    end
  endtask

  task automatic test_reset_abort;
    logic [W-1:0] q, r;
    logic z;
    int lat, bc, done_seen;
    run_div(1'b0, 16'h0055, 16'h0000, q, r, z, lat, bc);
    start = 1'b1; is_signed = 1'b0; dividend = 16'd200; divisor = 16'd9;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, expected all zero",
               quotient, remainder, busy, done, div_by_zero);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    done_seen = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles, expected 0", done_seen);
    end
    run_div(1'b0, 16'd9, 16'd3, q, r, z, lat, bc);
    checks++;
    if (q !== 16'd3 || r !== 16'd0 || z !== 1'b0 || lat !== 17) begin
      errors++;
      $display("FAIL after_reset_div: got q=%0d r=%0d dbz=%b latency=%0d, expected 3 0 0 17",
               q, r, z, lat);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, q, r, eq, er;
    logic s, z, ez;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = W'($urandom);
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: begin a = 16'h8000; b = s ? 16'hFFFF : W'($urandom); end
        default: b = W'($urandom);
      endcase
      model(s, a, b, eq, er, ez);
      run_div(s, a, b, q, r, z, lat, bc);
      checks++;
      if (q !== eq || r !== er || z !== ez || lat !== (ez ? 1 : 17)) begin
        errors++;
        $display("FAIL random_%0d s=%b %h/%h: got q=%h r=%h dbz=%b lat=%0d, expected q=%h r=%h dbz=%b lat=%0d",
                 i, s, a, b, q, r, z, lat, eq, er, ez, ez ? 1 : 17);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: width, 16, operand and result bit width.
REQ-002 Port: clock  input  1  clock; all state updates on the positive edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (asserted when 0); one clock, no other clock or reset.
REQ-004 Port: start  input  1  request a division; sampled on the clock edge.
REQ-005 Port: is_signed  input  1  0 = unsigned, 1 = two's-complement signed; sampled with start.
REQ-006 Port: dividend  input  width  numerator; sampled with start.
REQ-007 Port: divisor  input  width  denominator; sampled with start.
REQ-008 Port: quotient  output  width  result quotient, registered.
REQ-009 Port: remainder  output  width  result remainder, registered.
REQ-010 Port: busy  output  1  high while a division is in progress.
REQ-011 Port: done  output  1  single-cycle pulse, results valid; drives wren of the downstream result registers.
REQ-012 Port: div_by_zero  output  1  registered flag, valid with done, held until next accepted start.

Function
REQ-013 States SHALL be IDLE, BUSY, DONE; busy = (state==BUSY); done = (state==DONE).
REQ-014 start SHALL be accepted in IDLE or DONE (back-to-back); start in BUSY SHALL be ignored with no effect on operands or progress.
REQ-015 On the accepting edge, the unit SHALL latch is_signed, operand signs, and operand magnitudes (absolute values when is_signed=1, raw when 0), and clear div_by_zero.
REQ-016 If divisor==0 at acceptance, the next state SHALL be DONE, with quotient = all ones, remainder = dividend, div_by_zero = 1 (latency 1 edge, signed or unsigned).
REQ-017 Otherwise the next state SHALL be BUSY with an iteration counter loaded to width.
REQ-018 BUSY SHALL perform one restoring-division step per edge (shift partial remainder left by one, bring in next dividend MSB, subtract magnitude of divisor if non-negative result, set quotient bit), decrementing the counter.
REQ-019 On the edge completing the width-th step, state SHALL go to DONE and quotient/remainder SHALL be loaded with sign-corrected results; total latency = width+1 edges from the accepting edge to done high.
REQ-020 Signed results SHALL truncate toward zero: quotient negated when operand signs differ, remainder carries the sign of the dividend.
REQ-021 Signed overflow (most-negative / -1) SHALL give quotient = most-negative value, remainder = 0, div_by_zero = 0.
REQ-022 DONE SHALL last exactly one cycle, then IDLE unless start is accepted in that cycle.
REQ-023 quotient, remainder, div_by_zero SHALL hold their values in IDLE and BUSY until the next DONE load; intermediate iteration state SHALL not be visible on them.
REQ-024 Input changes on dividend, divisor, is_signed after acceptance SHALL not affect the running division.

Reset
REQ-025 While reset=0, state SHALL be IDLE and quotient, remainder, busy, done, div_by_zero, counter and internal registers SHALL be 0, independent of clock.
REQ-026 Reset asserted mid-division SHALL abort it; no done pulse SHALL follow for the aborted operation.
REQ-027 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 Unsigned 100 / 7 (width 16): start 1 cycle -> busy for 16 cycles, done at edge 17, quotient=14, remainder=2, div_by_zero=0.
REQ-029 Signed 0xFFF9 / 0x0002 (-7/2) -> quotient=0xFFFD (-3), remainder=0xFFFF (-1) at edge 17; unsigned same operands -> quotient=0x7FFC, remainder=0x0001.
REQ-030 Signed 0x8000 / 0xFFFF -> quotient=0x8000, remainder=0x0000, div_by_zero=0.
REQ-031 0x1234 / 0x0000 -> done at edge 1 after acceptance, quotient=0xFFFF, remainder=0x1234, div_by_zero=1.
REQ-032 Start 100/7, pulse start with 50/5 at cycle 5 and start again in the DONE cycle with 50/5 -> first result 14/2 unaffected, second accepted back-to-back, gives 10/0 16 edges later.
REQ-033 Start a division, drive reset=0 at cycle 8 -> all outputs 0 immediately, no done pulse; release reset, divide 9/3 -> quotient=3, remainder=0.
